// File: rtl/tia_timing_pkg.sv
// Shared horizontal-timing constants for the TIA core: count windows,
// line length and the colour-clock phase encoding.
package tia_timing_pkg;

   localparam int HCOUNT_MAX   = 56;
   localparam int HSYNC_START  = 4;
   localparam int HSYNC_END    = 7;
   localparam int CBURST_START = 9;
   localparam int CBURST_END   = 12;

   localparam int HBLANK_END_DEFAULT       = 16;
   localparam int HBLANK_END_HMOVE_DEFAULT = 18;

   typedef enum logic [1:0] {
      PH_0 = 2'd0,
      PH_1 = 2'd1,
      PH_2 = 2'd2,
      PH_3 = 2'd3
   } phase_e;

   function automatic logic in_window(input logic [5:0] hc, input int lo, input int hi);
      return (hc >= 6'(lo)) && (hc <= 6'(hi));
   endfunction

endpackage

// File: rtl/tia_hcount_core.sv
// Colour-clock phase divider plus the 57-state binary horizontal counter.
// clr_i restarts the line (phase 0, hcount 0) on the next edge.
module tia_hcount_core #(
   parameter int HCOUNT_MAX = tia_timing_pkg::HCOUNT_MAX
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr_i,
   output logic [1:0] phase_o,
   output logic [5:0] hcount_o,
   output logic       wrap_o
);
   import tia_timing_pkg::*;

   phase_e     phase_q, phase_d;
   logic [5:0] hcount_q, hcount_d;
   logic       at_end;

   // Out-of-range counts are treated like the terminal count so the
   // counter falls back to 0 at the next phase-3 edge.
   assign at_end = (hcount_q >= 6'(HCOUNT_MAX));

   always_comb begin
      phase_d  = phase_e'(phase_q + 2'd1);
      hcount_d = hcount_q;
      if (phase_q == PH_3) begin
         hcount_d = at_end ? 6'd0 : hcount_q + 6'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         phase_q  <= PH_0;
         hcount_q <= 6'd0;
      end else begin
         phase_q  <= phase_d;
         hcount_q <= hcount_d;
      end
   end

   assign phase_o  = phase_q;
   assign hcount_o = hcount_q;
   assign wrap_o   = (phase_q == PH_3) && at_end;

endmodule

// File: rtl/tia_hsync_ctrl.sv
// Horizontal timing controller: window decode of the line count, WSYNC/RSYNC/HMOVE
// servicing and the RDY line. Every output is decoded from registered state only.
module tia_hsync_ctrl #(
   parameter int HCOUNT_MAX       = tia_timing_pkg::HCOUNT_MAX,
   parameter int HBLANK_END       = tia_timing_pkg::HBLANK_END_DEFAULT,
   parameter int HBLANK_END_HMOVE = tia_timing_pkg::HBLANK_END_HMOVE_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wsync_strobe,
   input  logic       rsync_strobe,
   input  logic       hmove_strobe,
   output logic       hphi1,
   output logic       hphi2,
   output logic [5:0] hcount,
   output logic       line_start,
   output logic       hsync,
   output logic       hblank,
   output logic       cburst,
   output logic       hmove_blank,
   output logic       rdy
);
   import tia_timing_pkg::*;

   logic [1:0] phase;
   logic [5:0] hcount_w;
   logic       wrap;
   logic       hmove_q, hmove_d;
   logic       wsync_q, wsync_d;

   tia_hcount_core #(
      .HCOUNT_MAX(HCOUNT_MAX)
   ) u_core (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (rsync_strobe),
      .phase_o  (phase),
      .hcount_o (hcount_w),
      .wrap_o   (wrap)
   );

   // A strobe arriving on the wrap edge wins, so that line becomes an HMOVE
   // line or stays stalled for the whole following line.
   always_comb begin
      hmove_d = hmove_q;
      if (hmove_strobe) begin
         hmove_d = 1'b1;
      end else if (wrap) begin
         hmove_d = 1'b0;
      end

      wsync_d = wsync_q;
      if (rsync_strobe) begin
         wsync_d = 1'b0;
      end else if (wsync_strobe) begin
         wsync_d = 1'b1;
      end else if (wrap) begin
         wsync_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hmove_q <= 1'b0;
         wsync_q <= 1'b0;
      end else begin
         hmove_q <= hmove_d;
         wsync_q <= wsync_d;
      end
   end

   assign hphi1       = (phase == PH_1);
   assign hphi2       = (phase == PH_3);
   assign hcount      = hcount_w;
   assign line_start  = (hcount_w == 6'd0) && (phase == PH_0);
   assign hsync       = in_window(hcount_w, HSYNC_START, HSYNC_END);
   assign cburst      = in_window(hcount_w, CBURST_START, CBURST_END);
   assign hblank      = hmove_q ? (hcount_w < 6'(HBLANK_END_HMOVE))
                                : (hcount_w < 6'(HBLANK_END));
   assign hmove_blank = hmove_q;
   assign rdy         = ~wsync_q;

   a_phi_exclusive: assert property (@(posedge clk) disable iff (rst) !(hphi1 && hphi2));

endmodule
